piso_serializer: RTL and testbench

- Parallel-in, serial-out unloader: the read side of an N-bit register.
- Accepts an N-bit word with a single-cycle load handshake, then drives it out one bit per enabled clock.
- Pulses done after the last bit, then returns to idle.
- Sits between a datapath register or controller and any serial consumer (LED/shift chain, serial link, tester), with stall support via en.

---
 rtl/serializer_pkg.sv | 16 +
 rtl/down_counter_nbit.sv | 24 ++
 rtl/piso_serializer.sv | 69 ++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and counter sizing for piso_serializer.
// Contents: S_* state codes, state_e FSM type, cnt_width() counter width helper.
package serializer_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_DONE  = S_DONE
   } state_e;
   // Bits needed to hold a value in 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/down_counter_nbit.sv
// down_counter_nbit: loadable down-counter that saturates at zero.
// Ports: clk, clr (sync reset), ld (load in), en (decrement), in (load value),
//        out (current count), zero (count is zero).
module down_counter_nbit #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic         en,
   input  logic [W-1:0] in,
   output logic [W-1:0] out,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   assign out  = cnt_q;
   assign zero = (cnt_q == '0);
   // Decrement only when non-zero, so the count can never wrap.
   always_comb cnt_d = ld ? in : (en && !zero) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (clr) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out unloader with load handshake, stall and done pulse.
// Ports: clk, clr (sync reset, highest priority), ld (load request), en (shift enable),
//        in (parallel word), ready (IDLE), busy (SHIFT/DONE), sout (serial bit),
//        sout_valid (SHIFT), done (one-cycle pulse after last bit).
module piso_serializer
   import serializer_pkg::*;
#(
   parameter int N         = 12,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic         en,
   input  logic [N-1:0] in,
   output logic         ready,
   output logic         busy,
   output logic         sout,
   output logic         sout_valid,
   output logic         done
);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   state_e state_q, state_d;
   logic [N-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt;
   logic cnt_zero;
   logic accept, step;
   assign accept = (state_q == ST_IDLE) && ld;
   assign step   = (state_q == ST_SHIFT) && en;
   down_counter_nbit #(.W(CW)) u_cnt (
      .clk  (clk),
      .clr  (clr),
      .ld   (accept),
      .en   (step),
      .in   (LAST),
      .out  (cnt),
      .zero (cnt_zero)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ld ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_d = (en && cnt_zero) ? ST_DONE : ST_SHIFT;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end
   // Shift toward the output end with zero fill; the last step leaves contents don't-care.
   always_comb begin
      sr_d = sr_q;
      if (accept)                 sr_d = in;
      else if (step && cnt != '0) sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
      end
   end
   assign ready      = (state_q == ST_IDLE);
   assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign sout_valid = (state_q == ST_SHIFT);
   assign done       = (state_q == ST_DONE);
   assign sout       = sout_valid && (LSB_FIRST ? sr_q[0] : sr_q[N-1]);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for piso_serializer (N=12 MSB, N=1, N=8 LSB).
module tb_piso_serializer;
   logic clk = 1'b0;
   logic clr;
   logic ld_a, en_a, ld_b, en_b, ld_c, en_c;
   logic [11:0] in_a;
   logic [0:0]  in_b;
   logic [7:0]  in_c;
   logic ready_a, busy_a, sout_a, valid_a, done_a;
   logic ready_b, busy_b, sout_b, valid_b, done_b;
   logic ready_c, busy_c, sout_c, valid_c, done_c;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_load = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piso_serializer #(.N(12), .LSB_FIRST(1'b0)) dut_a (
      .clk(clk), .clr(clr), .ld(ld_a), .en(en_a), .in(in_a),
      .ready(ready_a), .busy(busy_a), .sout(sout_a), .sout_valid(valid_a), .done(done_a));
   piso_serializer #(.N(1), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .clr(clr), .ld(ld_b), .en(en_b), .in(in_b),
      .ready(ready_b), .busy(busy_b), .sout(sout_b), .sout_valid(valid_b), .done(done_b));
   piso_serializer #(.N(8), .LSB_FIRST(1'b1)) dut_c (
      .clk(clk), .clr(clr), .ld(ld_c), .en(en_c), .in(in_c),
      .ready(ready_c), .busy(busy_c), .sout(sout_c), .sout_valid(valid_c), .done(done_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, ".ready"}, ready_a, 1);
      chk({tag, ".busy"}, busy_a, 0);
      chk({tag, ".valid"}, valid_a, 0);
      chk({tag, ".done"}, done_a, 0);
      chk({tag, ".sout"}, sout_a, 0);
   endtask

   // Serialize one word on dut_a (MSB first), optionally stalling after bit stall_at
   // and optionally poking ignored loads in SHIFT and DONE.
   task automatic send_a(input logic [11:0] w, input int stall_at, input int stall_len,
                         input bit poke, input bit check_gap);
      in_a = w; ld_a = 1'b1; en_a = 1'b1;
      step();
      if (check_gap) chk("gap", cyc - last_load, 14);
      last_load = cyc;
      ld_a = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("bit", sout_a, w[11-i]);
         chk("bit.valid", valid_a, 1);
         chk("bit.done", done_a, 0);
         if (poke && i == 5) begin ld_a = 1'b1; in_a = 12'h000; end
         else ld_a = 1'b0;
         if (i == stall_at) begin
            en_a = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               step();
               chk("stall.sout", sout_a, w[11-i]);
               chk("stall.valid", valid_a, 1);
            end
            en_a = 1'b1;
         end
         step();
      end
      ld_a = poke;
      in_a = 12'h000;
      chk("done", done_a, 1);
      chk("done.busy", busy_a, 1);
      chk("done.valid", valid_a, 0);
      chk("done.sout", sout_a, 0);
      chk("done.ready", ready_a, 0);
      step();
      ld_a = 1'b0;
      chk_idle_a("post");
   endtask

   initial begin
      clr = 1'b1;
      ld_a = 1'b1; en_a = 1'b1; in_a = 12'hFFF;
      ld_b = 1'b1; en_b = 1'b1; in_b = 1'b1;
      ld_c = 1'b1; en_c = 1'b1; in_c = 8'hFF;
      step();
      step();
      chk_idle_a("reset");
      chk("reset.b.ready", ready_b, 1);
      chk("reset.c.ready", ready_c, 1);
      clr = 1'b0; ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
      step();
      chk_idle_a("reset.nocapture");

      send_a(12'hA5C, -1, 0, 1'b0, 1'b0);
      send_a(12'hA5C, 3, 3, 1'b0, 1'b0);
      send_a(12'hA5C, -1, 0, 1'b1, 1'b0);
      step();
      chk_idle_a("poke.idle");

      // Abort while the 6th bit is valid.
      in_a = 12'hA5C; ld_a = 1'b1; en_a = 1'b1;
      step();
      ld_a = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("abort.bit6", sout_a, 1);
      chk("abort.valid", valid_a, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_idle_a("abort");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort.nodone", done_a, 0);
      end
      send_a(12'h001, -1, 0, 1'b0, 1'b0);
      send_a(12'h3C5, -1, 0, 1'b0, 1'b1);
      send_a(12'h801, -1, 0, 1'b0, 1'b1);

      // N=1
      ld_b = 1'b1; in_b = 1'b1;
      step();
      ld_b = 1'b0;
      chk("b.sout", sout_b, 1);
      chk("b.valid", valid_b, 1);
      chk("b.done0", done_b, 0);
      step();
      chk("b.done", done_b, 1);
      chk("b.valid2", valid_b, 0);
      step();
      chk("b.ready", ready_b, 1);
      chk("b.done2", done_b, 0);

      // N=8, LSB first
      ld_c = 1'b1; in_c = 8'h81;
      step();
      ld_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("c.bit", sout_c, (i == 0 || i == 7) ? 1 : 0);
         chk("c.valid", valid_c, 1);
         step();
      end
      chk("c.done", done_c, 1);
      step();
      chk("c.ready", ready_c, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
